// File: rtl/dcache_pkg.sv
// Shared types and byte-lane helpers for the direct-mapped write-through data cache.
// Lanes are big-endian: lane 0 is word bits [31:24], lane 3 is bits [7:0].
package dcache_pkg;

    localparam int DC_ADDRESS_WIDTH = 32;
    localparam int DC_DATA_WIDTH    = 32;
    localparam int DC_SET_WIDTH     = 6;
    localparam int TAG_WIDTH        = DC_ADDRESS_WIDTH - DC_SET_WIDTH - 2;
    localparam int NUM_SETS         = 1 << DC_SET_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2
    } dcache_state_t;

    function automatic logic [31:0] byte_lane_merge(input logic [31:0] word,
                                                    input logic [7:0]  byte_val,
                                                    input logic [1:0]  lane);
        logic [31:0] merged;
        merged = word;
        case (lane)
            2'd0:    merged[31:24] = byte_val;
            2'd1:    merged[23:16] = byte_val;
            2'd2:    merged[15:8]  = byte_val;
            default: merged[7:0]   = byte_val;
        endcase
        return merged;
    endfunction

    function automatic logic [7:0] byte_lane_select(input logic [31:0] word,
                                                    input logic [1:0]  lane);
        logic [7:0] sel;
        case (lane)
            2'd0:    sel = word[31:24];
            2'd1:    sel = word[23:16];
            2'd2:    sel = word[15:8];
            default: sel = word[7:0];
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the data cache: asynchronous read, one synchronous write port.
// Only the valid bits are reset; tag and data contents are don't-care while invalid.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int SET_WIDTH  = DC_SET_WIDTH,
    parameter int TAG_W      = TAG_WIDTH,
    parameter int DATA_WIDTH = DC_DATA_WIDTH,
    parameter int SETS       = NUM_SETS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SET_WIDTH-1:0]  index,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    logic [SETS-1:0]       valid_q;
    logic [TAG_W-1:0]      tag_q  [SETS];
    logic [DATA_WIDTH-1:0] data_q [SETS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[index]  <= wr_tag;
            data_q[index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[index];
    assign rd_tag   = tag_q[index];
    assign rd_data  = data_q[index];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller in front of memory.
// Define DCACHE_STATS_EN to add the hit_count/miss_count load statistics outputs.
//
// state | meaning
// IDLE  | serve load hits combinationally; launch a fetch on a load miss or a write on a store
// FETCH | read outstanding; fill the line on mem_ack
// WRITE | write-through outstanding; merge into the line on mem_ack if it hits
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DC_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DC_DATA_WIDTH,
    parameter int SET_WIDTH     = DC_SET_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic                     cpu_byte_op,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     cpu_stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic                     mem_byte_op,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
`ifdef DCACHE_STATS_EN
    input  logic                     mem_ack,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
`else
    input  logic                     mem_ack
`endif
);

    localparam int TAG_W = ADDRESS_WIDTH - SET_WIDTH - 2;

    dcache_state_t state_q, state_d;

    logic                  done_q;
    logic                  finish;
    logic                  issue_read;
    logic                  issue_write;
    logic [SET_WIDTH-1:0]  index;
    logic [TAG_W-1:0]      addr_tag;
    logic                  line_valid;
    logic [TAG_W-1:0]      line_tag;
    logic [DATA_WIDTH-1:0] line_data;
    logic                  hit;
    logic                  arr_we;
    logic [DATA_WIDTH-1:0] arr_wdata;

    assign index    = cpu_addr[SET_WIDTH+1:2];
    assign addr_tag = cpu_addr[ADDRESS_WIDTH-1:SET_WIDTH+2];
    assign hit      = line_valid && (line_tag == addr_tag);

    dcache_array #(
        .SET_WIDTH  (SET_WIDTH),
        .TAG_W      (TAG_W),
        .DATA_WIDTH (DATA_WIDTH),
        .SETS       (1 << SET_WIDTH)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .index    (index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (arr_we),
        .wr_tag   (addr_tag),
        .wr_data  (arr_wdata)
    );

    assign cpu_rdata = cpu_byte_op
                     ? {{(DATA_WIDTH-8){1'b0}}, byte_lane_select(line_data, cpu_addr[1:0])}
                     : line_data;

    // done_q marks the cycle right after a completed transaction, where the CPU
    // still presents the finished access and must be released rather than reissued.
    always_comb begin
        state_d     = state_q;
        cpu_stall   = 1'b0;
        issue_read  = 1'b0;
        issue_write = 1'b0;
        finish      = 1'b0;
        arr_we      = 1'b0;
        arr_wdata   = mem_rdata;
        case (state_q)
            IDLE: begin
                if (cpu_req && !done_q) begin
                    if (cpu_we) begin
                        cpu_stall   = 1'b1;
                        issue_write = 1'b1;
                        state_d     = WRITE;
                    end else if (!hit) begin
                        cpu_stall  = 1'b1;
                        issue_read = 1'b1;
                        state_d    = FETCH;
                    end
                end
            end
            FETCH: begin
                cpu_stall = 1'b1;
                if (mem_ack) begin
                    arr_we  = 1'b1;
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                cpu_stall = 1'b1;
                if (mem_ack) begin
                    arr_we    = hit;
                    arr_wdata = cpu_byte_op
                              ? byte_lane_merge(line_data, cpu_wdata[7:0], cpu_addr[1:0])
                              : cpu_wdata;
                    finish    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_byte_op <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= finish;
            if (issue_read) begin
                mem_req     <= 1'b1;
                mem_we      <= 1'b0;
                mem_byte_op <= 1'b0;
                mem_addr    <= {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
                mem_wdata   <= '0;
            end else if (issue_write) begin
                mem_req     <= 1'b1;
                mem_we      <= 1'b1;
                mem_byte_op <= cpu_byte_op;
                mem_addr    <= cpu_addr;
                mem_wdata   <= cpu_wdata;
            end else if (finish) begin
                mem_req <= 1'b0;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_q == IDLE && cpu_req && !cpu_we && !done_q) begin
            if (hit) begin
                hit_count <= hit_count + 32'd1;
            end else begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed scoreboard bench for dcache_ctrl: expected load data and memory requests are
// queued when stimulus is driven and checked when the DUT completes them.
module tb_dcache_ctrl;

    typedef struct packed {
        logic        we;
        logic        bo;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic        cpu_byte_op;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic        mem_byte_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int          n_cmp;
    int          n_err;
    int          mem_lat;
    int          req_cycles;
    bit          auto_ack;
    bit          inject_tog;
    bit          inject_seen;
    logic [31:0] inject_data;

    mem_exp_t    exp_mem_q [$];
    logic [31:0] exp_rd_q  [$];
    logic [31:0] mem_model [logic [29:0]];

    dcache_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_byte_op (cpu_byte_op),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_stall   (cpu_stall),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_byte_op (mem_byte_op),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (mem_model.exists(a[31:2])) return mem_model[a[31:2]];
        return {a[31:2], 2'b00} ^ 32'h5A3C_96F0;
    endfunction

    function automatic logic [31:0] sel_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [31:0] s;
        s = word >> (5'd24 - {lane, 3'b000});
        return {24'h0, s[7:0]};
    endfunction

    function automatic logic [31:0] merge_byte(input logic [31:0] word, input logic [7:0] b,
                                               input logic [1:0] lane);
        logic [4:0] sh;
        sh = 5'd24 - {lane, 3'b000};
        return (word & ~(32'h0000_00FF << sh)) | ({24'h0, b} << sh);
    endfunction

    task automatic expect_mem(input logic we, input logic bo, input logic [31:0] addr,
                              input logic [31:0] wdata);
        mem_exp_t e;
        e.we = we; e.bo = bo; e.addr = addr; e.wdata = wdata;
        exp_mem_q.push_back(e);
    endtask

    // Drives one CPU access from posedge+1 and holds it until the stall drops.
    task automatic access(input logic we, input logic bo, input logic [31:0] addr,
                          input logic [31:0] wdata, input int exp_stall, input string tag);
        int          stalls;
        bit          done;
        logic [31:0] exp;
        stalls = 0;
        done   = 1'b0;
        cpu_req = 1'b1; cpu_we = we; cpu_byte_op = bo; cpu_addr = addr; cpu_wdata = wdata;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (cpu_stall) begin
                stalls++;
            end else begin
                done = 1'b1;
                if (!we) begin
                    exp = exp_rd_q.pop_front();
                    check({tag, " rdata"}, cpu_rdata, exp);
                end
                check({tag, " mem_req idle"}, 32'(mem_req), 32'd0);
            end
            @(posedge clk); #1;
        end
        check({tag, " completed"}, 32'(done), 32'd1);
        check({tag, " stall cycles"}, 32'(stalls), 32'(exp_stall));
        cpu_req = 1'b0;
    endtask

    task automatic load(input logic [31:0] addr, input logic bo, input logic [31:0] exp_data,
                        input bit miss, input string tag);
        if (miss) expect_mem(1'b0, 1'b0, {addr[31:2], 2'b00}, 32'h0);
        exp_rd_q.push_back(exp_data);
        access(1'b0, bo, addr, 32'h0, miss ? mem_lat + 1 : 0, tag);
    endtask

    task automatic store(input logic [31:0] addr, input logic bo, input logic [31:0] wdata,
                         input string tag);
        expect_mem(1'b1, bo, addr, wdata);
        access(1'b1, bo, addr, wdata, mem_lat + 1, tag);
    endtask

    initial begin
        mem_exp_t e;
        n_cmp = 0; n_err = 0; mem_lat = 3; req_cycles = 0; auto_ack = 1'b1;
        inject_tog = 1'b0; inject_seen = 1'b0; inject_data = '0;
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_byte_op = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        mem_model[30'h0000_4000] = 32'hDEAD_BEEF;

        // Memory responder: checks each request's first cycle, acks in cycle mem_lat.
        fork
            forever begin
                @(posedge clk); #1;
                mem_ack = 1'b0;
                if (inject_tog != inject_seen) begin
                    inject_seen = inject_tog;
                    mem_ack     = 1'b1;
                    mem_rdata   = inject_data;
                end else if (mem_req) begin
                    if (req_cycles == 0) begin
                        if (exp_mem_q.size() == 0) begin
                            check("unexpected mem_req", 32'(mem_req), 32'd0);
                        end else begin
                            e = exp_mem_q.pop_front();
                            check("mem_we", 32'(mem_we), 32'(e.we));
                            check("mem_byte_op", 32'(mem_byte_op), 32'(e.bo));
                            check("mem_addr", mem_addr, e.addr);
                            if (e.we) check("mem_wdata", mem_wdata, e.wdata);
                        end
                    end
                    req_cycles++;
                    if (auto_ack && req_cycles >= mem_lat) begin
                        mem_ack = 1'b1;
                        if (!mem_we) begin
                            mem_rdata = rd_model(mem_addr);
                        end else if (mem_byte_op) begin
                            mem_model[mem_addr[31:2]] =
                                merge_byte(rd_model(mem_addr), mem_wdata[7:0], mem_addr[1:0]);
                        end else begin
                            mem_model[mem_addr[31:2]] = mem_wdata;
                        end
                    end
                end else begin
                    req_cycles = 0;
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset mem_byte_op", 32'(mem_byte_op), 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset mem_wdata", mem_wdata, 32'd0);
        check("reset cpu_stall", 32'(cpu_stall), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        load(32'h0001_0000, 1'b0, 32'hDEAD_BEEF, 1'b1, "cold load");
        load(32'h0001_0000, 1'b0, 32'hDEAD_BEEF, 1'b0, "repeat load");
        load(32'h0001_0002, 1'b1, 32'h0000_00BE, 1'b0, "byte load hit");
        store(32'h0001_0001, 1'b1, 32'hAAAA_AA11, "byte store hit");
        load(32'h0001_0001, 1'b0, 32'hDE11_BEEF, 1'b0, "load after byte store");

        mem_lat = 1;
        store(32'h0001_0100, 1'b0, 32'h1234_5678, "word store uncached");
        load(32'h0001_0000, 1'b0, 32'hDE11_BEEF, 1'b0, "no allocate");
        load(32'h0001_0100, 1'b0, 32'h1234_5678, 1'b1, "alias fill");
        load(32'h0001_0000, 1'b0, 32'hDE11_BEEF, 1'b1, "alias evicted");
        load(32'h0001_0100, 1'b0, 32'h1234_5678, 1'b1, "alias evicted again");

        mem_lat = 2;
        load(32'h0002_0007, 1'b1, sel_byte(rd_model(32'h0002_0004), 2'd3), 1'b1, "byte load miss");
        load(32'h0002_0004, 1'b1, sel_byte(rd_model(32'h0002_0004), 2'd0), 1'b0, "byte lane0 hit");
        store(32'h0002_0004, 1'b0, 32'hCAFE_F00D, "word store hit");
        load(32'h0002_0004, 1'b0, 32'hCAFE_F00D, 1'b0, "load after word store");
        store(32'h0002_0006, 1'b1, 32'h0000_0077, "byte store lane2");
        load(32'h0002_0006, 1'b1, 32'h0000_0077, 1'b0, "byte load lane2");
        load(32'h0002_0004, 1'b0, 32'hCAFE_770D, 1'b0, "word after lane2 store");

        // Reset while a fetch is outstanding, then a stray ack afterwards.
        auto_ack = 1'b0;
        expect_mem(1'b0, 1'b0, 32'h0001_0200, 32'h0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte_op = 1'b0; cpu_addr = 32'h0001_0200;
        @(posedge clk); #1;
        @(negedge clk);
        check("fetch mem_req", 32'(mem_req), 32'd1);
        check("fetch cpu_stall", 32'(cpu_stall), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        check("post-reset mem_req", 32'(mem_req), 32'd0);
        check("post-reset cpu_stall", 32'(cpu_stall), 32'd0);
        inject_data = 32'hBAD0_BAD0;
        inject_tog  = ~inject_tog;
        @(negedge clk);
        @(negedge clk);
        check("stray ack mem_req", 32'(mem_req), 32'd0);
        check("stray ack cpu_stall", 32'(cpu_stall), 32'd0);
        @(negedge clk);
        check("after stray ack mem_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        auto_ack = 1'b1;
        load(32'h0001_0200, 1'b0, rd_model(32'h0001_0200), 1'b1, "reload after reset");
        load(32'h0002_0004, 1'b0, 32'hCAFE_770D, 1'b1, "cache invalid after reset");

        repeat (3) @(posedge clk);
        check("mem queue drained", 32'(exp_mem_q.size()), 32'd0);
        check("rdata queue drained", 32'(exp_rd_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- CPU-side initiator in front of the byte-addressed data memory.
- Direct-mapped, write-through, no-write-allocate data cache; 64 one-word sets.
- Resolves load hits in the same cycle; issues req/ack transactions to the backing memory on load misses and on all stores.
- Stalls the single-cycle CPU while a memory transaction is outstanding.

Parameters:
- ADDRESS_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width.
- SET_WIDTH, 6, index bits (64 sets); index = addr[SET_WIDTH+1:2], tag = addr[ADDRESS_WIDTH-1:SET_WIDTH+2].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU memory access this cycle.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_byte_op  in  1  1 = byte access, 0 = word access.
- cpu_addr  in  ADDRESS_WIDTH  byte address.
- cpu_wdata  in  DATA_WIDTH  store data; byte stores use [7:0].
- cpu_rdata  out  DATA_WIDTH  load data; valid when cpu_req && !cpu_stall.
- cpu_stall  out  1  hold the CPU; inputs must remain stable while high.
- mem_req  out  1  backing-memory request.
- mem_we  out  1  request is a write.
- mem_byte_op  out  1  request is a byte write.
- mem_addr  out  ADDRESS_WIDTH  request address; word-aligned for reads.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack.
- mem_ack  in  1  request completed this cycle.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - State returns to IDLE; all 64 valid bits cleared.
  - mem_req=0, mem_we=0, mem_byte_op=0, mem_addr=0, mem_wdata=0.
  - cpu_stall is combinational: 0 while IDLE with no miss.
- Byte order is big-endian. Byte lane k = addr[1:0] occupies word bits [31-8k:24-8k].
- Byte loads return the zero-extended byte; word loads ignore addr[1:0].
- Hit condition: valid[index] && tag_store[index] == addr tag.
- FSM states: IDLE, FETCH, WRITE.
- IDLE:
  - Load hit: cpu_rdata = cached word or selected byte, cpu_stall=0, zero added latency.
  - Load miss: cpu_stall=1; next state FETCH; mem_req=1, mem_we=0, mem_addr={addr[31:2],2'b00} from the next edge.
  - Store: cpu_stall=1; next state WRITE; mem_req=1, mem_we=1, mem_byte_op=cpu_byte_op, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - cpu_req=0: no action.
- FETCH: hold mem_* stable until mem_ack. On the ack edge:
  - Write mem_rdata to data[index], the tag to tag_store[index], and set valid.
  - Deassert mem_req and return to IDLE.
  - The next cycle is a hit, so cpu_stall drops.
  - Miss latency = memory latency + 1 cycle.
- WRITE: hold until mem_ack. On the ack edge:
  - If the line hits, merge the store into the cached word: full word for word stores, one lane for byte stores.
  - A miss leaves the cache untouched (no allocate).
  - Return to IDLE; cpu_stall=0 in the next cycle.
- Handshake:
  - mem_req may be acked in its first cycle.
  - mem_req is low for at least one cycle between transactions.
  - mem_ack while IDLE is ignored.
- Reset mid-transaction: request abandoned; any late mem_ack is ignored; the cache is invalid.
- Index aliasing: a fill overwrites the resident line unconditionally. Write-through means no data is lost.

Optional Feature:
- DCACHE_STATS_EN defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0].
  - Each counts once per completed load: a hit in IDLE, or a miss on entering FETCH.
  - Both counters wrap at 2^32 and clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- dcache_pkg:
  - dcache_state_t enum {IDLE, FETCH, WRITE}.
  - Localparams for TAG_WIDTH and NUM_SETS.
  - Function byte_lane_merge(word, byte, lane).
  - Function byte_lane_select(word, lane).
- Sub-module dcache_array holds valid/tag/data storage:
  - Asynchronous read; single synchronous write port.
  - Valid bits clear on synchronous reset.
- dcache_ctrl keeps the FSM, the hit compare and the memory interface.

Test Plan:
- Cold load word 0x0001_0000, memory acks after 3 cycles with 0xDEADBEEF -> stall high for 4 cycles, cpu_rdata=0xDEADBEEF; repeat load -> no stall, no mem_req.
- After that fill, byte load 0x0001_0002 -> 0x000000BE, no stall.
- Store byte 0x11 to 0x0001_0001 -> mem_req with mem_byte_op=1 and mem_addr=0x0001_0001; after ack, load -> 0xDE11BEEF from cache.
- Store word 0x12345678 to uncached 0x0001_0100 -> memory write only; next load misses and issues FETCH.
- Aliasing: load 0x0001_0000, then 0x0001_0100 (same index) -> second load misses; first address misses again afterwards.
- Assert rst_n=0 during FETCH, then ack 2 cycles later -> mem_req=0, state IDLE, ack ignored, next load of same address misses.
